// File: rtl/bsg_cache_dma_rr_arbiter.sv
// Round-robin arbiter sharing one bsg_cache DMA channel (pkt / read data / write data) between caches.
// Latency: 0 cycles on every path; pkt, write data and read data are combinational pass-throughs.
// Backpressure: a pkt is held until dma_pkt_yumi_i; write beats wait on dma_data_yumi_i; read beats wait on the head requester's ready.
//
// Ports:
//   clk_i, reset_n_i                  clock, asynchronous active-low reset
//   req_pkt_i/_v_i/_yumi_o            per-requester DMA pkt (valid/yumi)
//   req_data_o/_v_o/_ready_i          read data back to requesters; data is broadcast, valid is per requester
//   req_data_i/_v_i/_yumi_o           write data from requesters (valid/yumi)
//   dma_pkt_o/_v_o/_yumi_i            granted pkt to the downstream DMA target
//   dma_data_i/_v_i/_ready_o          read data from downstream (valid/ready)
//   dma_data_o/_v_o/_yumi_i           write data to downstream (valid/yumi)
//   grant_cnt_o                       per-requester 32-bit saturating grant counters
//
// Build option: define BSG_CACHE_DMA_ARB_STATS_EN to build the grant counters;
// without it grant_cnt_o is tied to zero.
//
// A pkt is {write_not_read, addr, mask} with write_not_read in the MSB.

module bsg_cache_dma_rr_arbiter #(
  parameter int num_req_p      = 4,
  parameter int addr_width_p   = 30,
  parameter int mask_width_p   = 8,
  parameter int data_width_p   = 64,
  parameter int burst_len_p    = 4,
  parameter int rd_fifo_els_p  = 4,
  localparam int pkt_width_lp  = 1 + addr_width_p + mask_width_p
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,

  input  logic [num_req_p*pkt_width_lp-1:0] req_pkt_i,
  input  logic [num_req_p-1:0]              req_pkt_v_i,
  output logic [num_req_p-1:0]              req_pkt_yumi_o,

  output logic [num_req_p*data_width_p-1:0] req_data_o,
  output logic [num_req_p-1:0]              req_data_v_o,
  input  logic [num_req_p-1:0]              req_data_ready_i,

  input  logic [num_req_p*data_width_p-1:0] req_data_i,
  input  logic [num_req_p-1:0]              req_data_v_i,
  output logic [num_req_p-1:0]              req_data_yumi_o,

  output logic [pkt_width_lp-1:0]           dma_pkt_o,
  output logic                              dma_pkt_v_o,
  input  logic                              dma_pkt_yumi_i,

  input  logic [data_width_p-1:0]           dma_data_i,
  input  logic                              dma_data_v_i,
  output logic                              dma_data_ready_o,

  output logic [data_width_p-1:0]           dma_data_o,
  output logic                              dma_data_v_o,
  input  logic                              dma_data_yumi_i,

  output logic [num_req_p*32-1:0]           grant_cnt_o
);

  localparam int id_w_lp     = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int rd_ptr_w_lp = (rd_fifo_els_p > 1) ? $clog2(rd_fifo_els_p) : 1;
  localparam int rd_cnt_w_lp = $clog2(rd_fifo_els_p + 1);
  localparam int beat_w_lp   = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;

  localparam logic [beat_w_lp-1:0]   last_beat_lp   = beat_w_lp'(burst_len_p - 1);
  localparam logic [rd_cnt_w_lp-1:0] rd_full_cnt_lp = rd_cnt_w_lp'(rd_fifo_els_p);
  localparam logic [rd_ptr_w_lp-1:0] rd_last_ptr_lp = rd_ptr_w_lp'(rd_fifo_els_p - 1);
  localparam logic [id_w_lp-1:0]     last_id_lp     = id_w_lp'(num_req_p - 1);

  typedef struct packed {
    logic                    write_not_read;
    logic [addr_width_p-1:0] addr;
    logic [mask_width_p-1:0] mask;
  } dma_pkt_s;

  typedef enum logic [0:0] {
    IDLE_S  = 1'b0,
    WDATA_S = 1'b1
  } state_e;

  dma_pkt_s [num_req_p-1:0]                   req_pkts;
  logic     [num_req_p-1:0][data_width_p-1:0] req_wdata;

  assign req_pkts  = req_pkt_i;
  assign req_wdata = req_data_i;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                                    state_q, state_d;
  logic [id_w_lp-1:0]                        rr_ptr_q, rr_ptr_d;
  logic                                      lock_q, lock_d;
  logic [id_w_lp-1:0]                        lock_id_q, lock_id_d;
  logic [id_w_lp-1:0]                        owner_q, owner_d;
  logic [beat_w_lp-1:0]                      wcnt_q, wcnt_d;
  logic [beat_w_lp-1:0]                      rcnt_q, rcnt_d;
  logic [rd_fifo_els_p-1:0][id_w_lp-1:0]     rd_mem_q, rd_mem_d;
  logic [rd_ptr_w_lp-1:0]                    rd_wptr_q, rd_wptr_d;
  logic [rd_ptr_w_lp-1:0]                    rd_rptr_q, rd_rptr_d;
  logic [rd_cnt_w_lp-1:0]                    rd_cnt_q, rd_cnt_d;

  // ---------------------------------------------------------------------------
  // Packet arbitration
  // ---------------------------------------------------------------------------
  logic                 rd_empty, rd_full;
  logic [num_req_p-1:0] eligible;
  logic                 pick_found;
  logic [id_w_lp-1:0]   pick_id;
  logic [id_w_lp-1:0]   winner_id;
  logic                 winner_v;
  logic                 pkt_fire;
  logic                 rd_push;

  assign rd_empty = (rd_cnt_q == '0);
  assign rd_full  = (rd_cnt_q == rd_full_cnt_lp);

  // Reads need a slot to remember who gets the returning burst; writes never wait.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < num_req_p; i++) begin
      eligible[i] = req_pkt_v_i[i] & (req_pkts[i].write_not_read | ~rd_full);
    end
  end

  // First eligible requester at or after the round-robin pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = 0; k < num_req_p; k++) begin
      if (!pick_found && eligible[(int'(rr_ptr_q) + k) % num_req_p]) begin
        pick_found = 1'b1;
        pick_id    = id_w_lp'((int'(rr_ptr_q) + k) % num_req_p);
      end
    end
  end

  // Once a pkt has been offered and not taken, keep offering the same one so the
  // downstream never sees the pkt change underneath a pending valid.
  assign winner_id = lock_q ? lock_id_q : pick_id;
  assign winner_v  = lock_q ? eligible[lock_id_q] : pick_found;

  assign dma_pkt_o   = req_pkts[winner_id];
  assign dma_pkt_v_o = reset_n_i & (state_q == IDLE_S) & winner_v;
  assign pkt_fire    = dma_pkt_v_o & dma_pkt_yumi_i;
  assign rd_push     = pkt_fire & ~req_pkts[winner_id].write_not_read;

  always_comb begin
    req_pkt_yumi_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      req_pkt_yumi_o[i] = pkt_fire & (winner_id == id_w_lp'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Write data path: owner of the current write burst talks straight to downstream
  // ---------------------------------------------------------------------------
  logic wr_fire;

  assign dma_data_o   = req_wdata[owner_q];
  assign dma_data_v_o = reset_n_i & (state_q == WDATA_S) & req_data_v_i[owner_q];
  assign wr_fire      = dma_data_v_o & dma_data_yumi_i;

  always_comb begin
    req_data_yumi_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      req_data_yumi_o[i] = wr_fire & (owner_q == id_w_lp'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Read return path: bursts come back in issue order, so the fifo head owns them
  // ---------------------------------------------------------------------------
  logic [id_w_lp-1:0] rd_head;
  logic               rd_fire;
  logic               rd_pop;

  assign rd_head          = rd_mem_q[rd_rptr_q];
  assign req_data_o       = {num_req_p{dma_data_i}};
  assign dma_data_ready_o = reset_n_i & ~rd_empty & req_data_ready_i[rd_head];
  assign rd_fire          = dma_data_v_i & dma_data_ready_o;
  assign rd_pop           = rd_fire & (rcnt_q == last_beat_lp);

  always_comb begin
    req_data_v_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      req_data_v_o[i] = reset_n_i & dma_data_v_i & ~rd_empty & (rd_head == id_w_lp'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    owner_d   = owner_q;
    wcnt_d    = wcnt_q;

    unique case (state_q)
      IDLE_S: begin
        if (pkt_fire) begin
          lock_d   = 1'b0;
          rr_ptr_d = (winner_id == last_id_lp) ? '0 : winner_id + id_w_lp'(1);
          if (req_pkts[winner_id].write_not_read) begin
            owner_d = winner_id;
            wcnt_d  = '0;
            state_d = WDATA_S;
          end
        end else if (dma_pkt_v_o) begin
          lock_d    = 1'b1;
          lock_id_d = winner_id;
        end else begin
          lock_d = 1'b0;
        end
      end
      WDATA_S: begin
        if (wr_fire) begin
          if (wcnt_q == last_beat_lp) begin
            wcnt_d  = '0;
            state_d = IDLE_S;
          end else begin
            wcnt_d = wcnt_q + beat_w_lp'(1);
          end
        end
      end
      default: state_d = IDLE_S;
    endcase
  end

  // Read-order fifo. On a full fifo a read grant is already masked by eligibility,
  // so a same-cycle push and pop can never overflow.
  always_comb begin
    rd_mem_d  = rd_mem_q;
    rd_wptr_d = rd_wptr_q;
    rd_rptr_d = rd_rptr_q;
    rcnt_d    = rcnt_q;
    rd_cnt_d  = rd_cnt_q + rd_cnt_w_lp'(rd_push) - rd_cnt_w_lp'(rd_pop);

    if (rd_push) begin
      rd_mem_d[rd_wptr_q] = winner_id;
      rd_wptr_d = (rd_wptr_q == rd_last_ptr_lp) ? '0 : rd_wptr_q + rd_ptr_w_lp'(1);
    end
    if (rd_fire) begin
      rcnt_d = (rcnt_q == last_beat_lp) ? '0 : rcnt_q + beat_w_lp'(1);
    end
    if (rd_pop) begin
      rd_rptr_d = (rd_rptr_q == rd_last_ptr_lp) ? '0 : rd_rptr_q + rd_ptr_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE_S;
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      owner_q   <= '0;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      rd_mem_q  <= '0;
      rd_wptr_q <= '0;
      rd_rptr_q <= '0;
      rd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      owner_q   <= owner_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      rd_mem_q  <= rd_mem_d;
      rd_wptr_q <= rd_wptr_d;
      rd_rptr_q <= rd_rptr_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Grant statistics
  // ---------------------------------------------------------------------------
`ifdef BSG_CACHE_DMA_ARB_STATS_EN
  logic [num_req_p-1:0][31:0] grant_cnt_q, grant_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    for (int i = 0; i < num_req_p; i++) begin
      if (req_pkt_yumi_o[i] && (grant_cnt_q[i] != '1)) begin
        grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      grant_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign grant_cnt_o = grant_cnt_q;
`else
  assign grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bsg_cache_dma_rr_arbiter.sv
// Bench for the DMA round-robin arbiter: directed reset/write checks, then
// randomized traffic compared every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_bsg_cache_dma_rr_arbiter;

  localparam int NUM = 4;
  localparam int AW  = 30;
  localparam int MW  = 8;
  localparam int DW  = 64;
  localparam int BL  = 4;
  localparam int ELS = 2;
  localparam int PW  = 1 + AW + MW;
  localparam int N_CYC = 4000;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [NUM*PW-1:0]   req_pkt_i;
  logic [NUM-1:0]      req_pkt_v_i;
  logic [NUM-1:0]      req_pkt_yumi_o;
  logic [NUM*DW-1:0]   req_data_o;
  logic [NUM-1:0]      req_data_v_o;
  logic [NUM-1:0]      req_data_ready_i;
  logic [NUM*DW-1:0]   req_data_i;
  logic [NUM-1:0]      req_data_v_i;
  logic [NUM-1:0]      req_data_yumi_o;
  logic [PW-1:0]       dma_pkt_o;
  logic                dma_pkt_v_o;
  logic                dma_pkt_yumi_i;
  logic [DW-1:0]       dma_data_i;
  logic                dma_data_v_i;
  logic                dma_data_ready_o;
  logic [DW-1:0]       dma_data_o;
  logic                dma_data_v_o;
  logic                dma_data_yumi_i;
  logic [NUM*32-1:0]   grant_cnt_o;

  always #5 clk = ~clk;

  bsg_cache_dma_rr_arbiter #(
    .num_req_p(NUM), .addr_width_p(AW), .mask_width_p(MW),
    .data_width_p(DW), .burst_len_p(BL), .rd_fifo_els_p(ELS)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_pkt_i(req_pkt_i), .req_pkt_v_i(req_pkt_v_i), .req_pkt_yumi_o(req_pkt_yumi_o),
    .req_data_o(req_data_o), .req_data_v_o(req_data_v_o), .req_data_ready_i(req_data_ready_i),
    .req_data_i(req_data_i), .req_data_v_i(req_data_v_i), .req_data_yumi_o(req_data_yumi_o),
    .dma_pkt_o(dma_pkt_o), .dma_pkt_v_o(dma_pkt_v_o), .dma_pkt_yumi_i(dma_pkt_yumi_i),
    .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_ready_o(dma_data_ready_o),
    .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_yumi_i(dma_data_yumi_i),
    .grant_cnt_o(grant_cnt_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every handshake output must be low while reset is asserted.
  task automatic chk_quiet(input string tag);
    chk({tag, ".pkt_v"},   dma_pkt_v_o, 0);
    chk({tag, ".pkt_yumi"}, req_pkt_yumi_o, 0);
    chk({tag, ".wdat_v"},  dma_data_v_o, 0);
    chk({tag, ".wdat_yumi"}, req_data_yumi_o, 0);
    chk({tag, ".rd_v"},    req_data_v_o, 0);
    chk({tag, ".rd_rdy"},  dma_data_ready_o, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: requesters, read-order queue, write burst tracking
  // ---------------------------------------------------------------------------
  bit          pend [NUM];
  logic [PW-1:0] pkt_r [NUM];
  logic [DW-1:0] wdat  [NUM];
  int          gcnt  [NUM];
  int          m_rq [$];
  int          m_rr, m_owner, m_wbeats, m_rbeat, m_hold_id;
  bit          m_wr, m_hold;

  function automatic bit m_elig(int i);
    return pend[i] && (pkt_r[i][PW-1] || (m_rq.size() < ELS));
  endfunction

  task automatic m_pick(output bit pv, output int win);
    pv  = 1'b0;
    win = 0;
    if (!m_wr) begin
      if (m_hold) begin
        win = m_hold_id;
        pv  = m_elig(m_hold_id);
      end else begin
        for (int k = 0; k < NUM; k++) begin
          if (!pv && m_elig((m_rr + k) % NUM)) begin
            pv  = 1'b1;
            win = (m_rr + k) % NUM;
          end
        end
      end
    end
  endtask

  function automatic logic [NUM*32-1:0] exp_gcnt();
    logic [NUM*32-1:0] r;
    r = '0;
`ifdef BSG_CACHE_DMA_ARB_STATS_EN
    for (int i = 0; i < NUM; i++) r[i*32 +: 32] = gcnt[i];
`endif
    return r;
  endfunction

  bit            exp_pv, exp_dv, exp_rdy, has_rd;
  bit            pkt_take, wr_take, rd_take;
  int            exp_win, head;
  logic [NUM-1:0] exp_rv, exp_py, exp_wy;
  logic [PW-1:0]  dpkt;
  logic [NUM*32-1:0] exp_g;

  initial begin
    reset_n          = 1'b0;
    req_pkt_i        = '0;
    req_pkt_v_i      = '0;
    req_data_ready_i = '0;
    req_data_i       = '0;
    req_data_v_i     = '0;
    dma_pkt_yumi_i   = 1'b0;
    dma_data_i       = '0;
    dma_data_v_i     = 1'b0;
    dma_data_yumi_i  = 1'b0;

    // ---- reset with every input asserted ----
    repeat (2) @(negedge clk);
    for (int i = 0; i < NUM; i++) req_pkt_i[i*PW +: PW] = {1'b0, AW'(i), 8'hff};
    req_pkt_v_i = '1; req_data_v_i = '1; req_data_ready_i = '1;
    dma_data_v_i = 1'b1; dma_pkt_yumi_i = 1'b1; dma_data_yumi_i = 1'b1;
    #1;
    chk_quiet("rst");
    chk("rst.gcnt", grant_cnt_o, 0);

    // ---- req1 write to 0x100, two of four beats, then async reset ----
    @(negedge clk);
    reset_n = 1'b1;
    req_pkt_v_i = '0; req_data_v_i = '0; req_data_ready_i = '0;
    dma_data_v_i = 1'b0; dma_pkt_yumi_i = 1'b0; dma_data_yumi_i = 1'b0;
    dpkt = {1'b1, 30'h100, 8'hff};
    req_pkt_i[1*PW +: PW] = dpkt;
    req_pkt_v_i = 4'b0010;
    #1;
    chk("wr.pkt_v", dma_pkt_v_o, 1);
    chk("wr.pkt", dma_pkt_o, dpkt);
    dma_pkt_yumi_i = 1'b1;
    #1;
    chk("wr.pkt_yumi", req_pkt_yumi_o, 4'b0010);
    @(negedge clk);
    dma_pkt_yumi_i = 1'b0;
    req_pkt_i[0 +: PW] = {1'b0, 30'h40, 8'hff};
    req_pkt_v_i = 4'b0001;
    for (int b = 0; b < 2; b++) begin
      req_data_i[1*DW +: DW] = 64'hA0 + 64'(b);
      req_data_v_i = 4'b0011;
      dma_data_yumi_i = 1'b1;
      #1;
      chk("wr.no_pkt", dma_pkt_v_o, 0);
      chk("wr.beat_v", dma_data_v_o, 1);
      chk("wr.beat", dma_data_o, 64'hA0 + 64'(b));
      chk("wr.beat_yumi", req_data_yumi_o, 4'b0010);
      @(negedge clk);
    end
    req_data_i[1*DW +: DW] = 64'hA2;
    req_pkt_i[3*PW +: PW] = {1'b0, 30'h80, 8'hff};
    req_pkt_v_i = 4'b1001; req_data_v_i = '1; req_data_ready_i = '1;
    dma_data_v_i = 1'b1; dma_pkt_yumi_i = 1'b1; dma_data_yumi_i = 1'b1;
    #1 reset_n = 1'b0;
    #1 chk_quiet("rst_mid");
    #1;
    dma_pkt_yumi_i = 1'b0; dma_data_yumi_i = 1'b0;
    reset_n = 1'b1;
    #1;
    chk("post.pkt_v", dma_pkt_v_o, 1);
    chk("post.pkt_ptr0", dma_pkt_o, {1'b0, 30'h40, 8'hff});
    chk("post.idle_wdat", dma_data_v_o, 0);
    chk("post.fifo_empty", dma_data_ready_o, 0);
    chk("post.rd_v", req_data_v_o, 0);

    // ---- random phase ----
    @(negedge clk);
    reset_n = 1'b0;
    req_pkt_v_i = '0; req_data_v_i = '0; req_data_ready_i = '0; dma_data_v_i = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < NUM; i++) begin
      pend[i] = 1'b0; gcnt[i] = 0;
      pkt_r[i] = '0; wdat[i] = {$urandom, $urandom};
    end
    m_rq.delete();
    m_rr = 0; m_wr = 1'b0; m_owner = 0; m_wbeats = 0; m_rbeat = 0;
    m_hold = 1'b0; m_hold_id = 0;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NUM; i++) begin
        req_pkt_i[i*PW +: PW] = pkt_r[i];
        req_pkt_v_i[i]        = pend[i];
        req_data_i[i*DW +: DW] = wdat[i];
        req_data_v_i[i]       = ($urandom_range(0, 3) != 0);
        req_data_ready_i[i]   = ($urandom_range(0, 3) != 0);
      end
      dma_data_v_i    = ($urandom_range(0, 1) == 1);
      dma_data_i      = {$urandom, $urandom};
      dma_pkt_yumi_i  = 1'b0;
      dma_data_yumi_i = 1'b0;
      #1;

      m_pick(exp_pv, exp_win);
      chk("pkt_v", dma_pkt_v_o, exp_pv);
      if (exp_pv) chk("pkt", dma_pkt_o, pkt_r[exp_win]);

      exp_dv = m_wr && req_data_v_i[m_owner];
      chk("wdat_v", dma_data_v_o, exp_dv);
      if (exp_dv) chk("wdat", dma_data_o, wdat[m_owner]);

      has_rd  = (m_rq.size() > 0);
      head    = has_rd ? m_rq[0] : 0;
      exp_rdy = has_rd && req_data_ready_i[head];
      exp_rv  = '0;
      if (has_rd && dma_data_v_i) exp_rv[head] = 1'b1;
      chk("rd_rdy", dma_data_ready_o, exp_rdy);
      chk("rd_v", req_data_v_o, exp_rv);
      chk("rd_dat", req_data_o, {NUM{dma_data_i}});

      pkt_take = exp_pv && ($urandom_range(0, 1) == 1);
      wr_take  = exp_dv && ($urandom_range(0, 1) == 1);
      dma_pkt_yumi_i  = pkt_take;
      dma_data_yumi_i = wr_take;
      #1;
      exp_py = '0;
      if (pkt_take) exp_py[exp_win] = 1'b1;
      exp_wy = '0;
      if (wr_take) exp_wy[m_owner] = 1'b1;
      chk("pkt_yumi", req_pkt_yumi_o, exp_py);
      chk("wdat_yumi", req_data_yumi_o, exp_wy);

      // model update for the coming clock edge
      rd_take = dma_data_v_i && exp_rdy;
      if (rd_take) begin
        m_rbeat++;
        if (m_rbeat == BL) begin
          void'(m_rq.pop_front());
          m_rbeat = 0;
        end
      end
      if (wr_take) begin
        wdat[m_owner] = {$urandom, $urandom};
        m_wbeats++;
        if (m_wbeats == BL) m_wr = 1'b0;
      end
      if (pkt_take) begin
        gcnt[exp_win]++;
        pend[exp_win] = 1'b0;
        m_rr   = (exp_win + 1) % NUM;
        m_hold = 1'b0;
        if (pkt_r[exp_win][PW-1]) begin
          m_wr = 1'b1; m_owner = exp_win; m_wbeats = 0;
        end else begin
          m_rq.push_back(exp_win);
        end
      end else begin
        m_hold    = exp_pv;
        m_hold_id = exp_win;
      end
      for (int i = 0; i < NUM; i++) begin
        if (!pend[i] && ($urandom_range(0, 3) == 0)) begin
          pend[i]  = 1'b1;
          pkt_r[i] = {($urandom_range(0, 2) == 0), AW'($urandom), MW'($urandom)};
        end
      end

      if ((cyc % 256) == 255) begin
        @(posedge clk);
        #1;
        chk("gcnt_periodic", grant_cnt_o, exp_gcnt());
      end
    end

    @(posedge clk);
    #1;
    exp_g = exp_gcnt();
    for (int i = 0; i < NUM; i++) chk("gcnt_final", grant_cnt_o[i*32 +: 32], exp_g[i*32 +: 32]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
